tdo_reclock_ctrl: RTL and testbench
===================================

Name: tdo_reclock_ctrl

Overview:
Controller for the target-TDO relatch countermeasure path in the TinyFPGA BX build. It qualifies PLL lock, then sequences the TDO output between raw bypass, fixed relatch and jittered relatch. In jittered relatch, each TDO edge is released after an LFSR-chosen delay to decorrelate edge timing from target activity. It sits between the TDO input pin and the attacker-facing TDO output pin, in the PLL clock domain.

Parameters:
SYNC_STAGES, 2, synchroniser depth for tdo_in and pll_locked (legal 2..4).
LOCK_CYCLES, 1024, consecutive synchronised-lock cycles required before ACTIVE (legal 2..65535).
JITTER_BITS, 3, width of random delay; delay d in 0..2^JITTER_BITS-1 (legal 1..8).
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clock  input  1  PLL output clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
pll_locked  input  1  PLL LOCK, asynchronous to clock.
tdo_in  input  1  TDO from target, asynchronous.
mode  input  2  00 bypass, 01 relatch, 10 jitter relatch, 11 treated as 10.
tdo_out  output  1  TDO toward attacker/host.
active  output  1  high while FSM is in ACTIVE.
lock_lost  output  1  sticky: set on any ACTIVE->WAIT_LOCK transition.
edge_count  output  16  saturating count of tdo_q transitions while ACTIVE.

Behaviour:
- Reset values: state=WAIT_LOCK, sync chains=0, tdo_q=0, pending=0, cnt=0, lock_cnt=0, mode_q=00, lfsr=LFSR_SEED, active=0, lock_lost=0, edge_count=0.
- tdo_out = tdo_in (combinational) when state!=ACTIVE or mode_q==00; otherwise tdo_out = tdo_q. Reset therefore yields bypass.
- Sync: tdo_s and lock_s are the final stages of SYNC_STAGES-deep flop chains.
- FSM WAIT_LOCK: lock_cnt=0; if lock_s=1 go QUALIFY.
- FSM QUALIFY: lock_cnt increments each cycle lock_s=1. If lock_s=0, go WAIT_LOCK. When lock_cnt reaches LOCK_CYCLES-1 with lock_s=1, go ACTIVE; active rises the same edge.
- FSM ACTIVE: lock_s=0 -> WAIT_LOCK, set lock_lost, clear pending/cnt, tdo_q<=tdo_s.
- Outside ACTIVE: tdo_q<=tdo_s every cycle, so there is no stale value on entry.
- mode_q<=mode only when state!=ACTIVE or pending=0. A mode change never aborts a pending delay.
- Relatch (mode_q=01): tdo_q<=tdo_s every cycle. Latency is SYNC_STAGES+1 edges from tdo_in to tdo_out.
- Jitter (mode_q=10/11):
  - Idle and tdo_s!=tdo_q: load cnt<=lfsr[JITTER_BITS-1:0] and set pending.
  - pending and cnt==0: tdo_q<=tdo_s and clear pending.
  - pending and cnt!=0: cnt<=cnt-1.
  - Latency is SYNC_STAGES+2+d edges.
  - Changes arriving while pending do not restart cnt; the latest tdo_s is released at expiry. Pulses shorter than the delay may be swallowed; this is accepted.
- LFSR: 16-bit Galois, taps mask 16'hB400, shifts right every cycle regardless of state. It must never reach 0.
- edge_count increments on any ACTIVE cycle where tdo_q changes, and saturates at 16'hFFFF. It is not cleared by lock loss.
- lock_lost is cleared only by reset.
- Reset asserted mid-delay: all state returns to reset values on that edge, and tdo_out reverts to bypass.

Decomposition:
- Shared package reclock_pkg holds:
  - FSM state encodings (WAIT_LOCK=0, QUALIFY=1, ACTIVE=2).
  - Mode encodings (MODE_BYPASS, MODE_RELATCH, MODE_JITTER).
  - LFSR_TAPS=16'hB400.
- One sub-module, lfsr16_galois: clock, reset, seed parameter, 16-bit state output, free-running.
- Synchronisers are inline flop chains.

Test Plan:
- Reset, then hold pll_locked=1 with LOCK_CYCLES=16, SYNC_STAGES=2 -> active rises exactly 2+16 edges after reset release. tdo_out follows tdo_in combinationally until then.
- ACTIVE, mode=01, toggle tdo_in 0->1 -> tdo_out rises on the 3rd edge. edge_count=1.
- ACTIVE, mode=10, JITTER_BITS=3, seed 16'hACE1 -> for each of 20 edges, latency equals 4+d. d is taken from the reference-model LFSR low 3 bits at the detect edge. All delays are in 0..7.
- Jitter mode, tdo_in pulses high for 1 cycle while pending with d=5 -> tdo_out shows no pulse and edge_count is unchanged. With a 10-cycle pulse -> tdo_out pulses, edge_count+=2.
- ACTIVE, deassert pll_locked for 1 cycle -> after 2 edges state=WAIT_LOCK, active=0, lock_lost=1, tdo_out=tdo_in. Reassert -> re-qualifies in 16 cycles, and lock_lost stays 1.
- Change mode 10->01 while pending -> mode_q holds 10 until the release edge, then switches. Force edge_count to 16'hFFFE, toggle twice -> edge_count stays at 16'hFFFF.

Source files
------------

// File: rtl/reclock_pkg.sv
// Shared encodings for the TDO relatch countermeasure controller.
// Also holds the Galois LFSR step used by the jitter source.
package reclock_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      QUALIFY   = 2'd1,
      ACTIVE    = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MODE_BYPASS  = 2'b00,
      MODE_RELATCH = 2'b01,
      MODE_JITTER  = 2'b10
   } mode_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) begin
         n = n ^ LFSR_TAPS;
      end
      return n;
   endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// Free-running 16-bit right-shifting Galois LFSR.
// A zero seed is replaced so the register can never stick at zero.
module lfsr16_galois
   import reclock_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   output logic [15:0] state_o
);

   localparam logic [15:0] SEED_NZ = (SEED == 16'h0) ? 16'h0001 : SEED;

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d = lfsr_next(lfsr_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_q <= SEED_NZ;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/tdo_reclock_ctrl.sv
// TDO relatch controller: qualifies PLL lock, then drives TDO as
// raw bypass, fixed relatch, or relatch with LFSR-jittered release.
module tdo_reclock_ctrl
   import reclock_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LOCK_CYCLES = 1024,
   parameter int unsigned JITTER_BITS = 3,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pll_locked,
   input  logic        tdo_in,
   input  logic [1:0]  mode,
   output logic        tdo_out,
   output logic        active,
   output logic        lock_lost,
   output logic [15:0] edge_count
);

   localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
   localparam logic [JITTER_BITS-1:0] CNT_ONE = JITTER_BITS'(1);

   logic [SYNC_STAGES-1:0] tdo_sync_q;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   tdo_s;
   logic                   lock_s;

   state_e                 state_q, state_d;
   logic [15:0]            lock_cnt_q, lock_cnt_d;
   logic [15:0]            lock_inc;
   logic                   tdo_q, tdo_d;
   logic                   pend_q, pend_d;
   logic [JITTER_BITS-1:0] cnt_q, cnt_d;
   logic [1:0]             mode_q, mode_d;
   logic                   active_q, active_d;
   logic                   lost_q, lost_d;
   logic [15:0]            edge_cnt_q, edge_cnt_d;

   logic [15:0]            lfsr;
   logic                   lfsr_unused;

   lfsr16_galois #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clock  (clock),
      .reset  (reset),
      .state_o(lfsr)
   );

   assign lfsr_unused = ^lfsr[15:JITTER_BITS];

   always_ff @(posedge clock) begin
      if (reset) begin
         tdo_sync_q  <= '0;
         lock_sync_q <= '0;
      end else begin
         tdo_sync_q  <= {tdo_sync_q[SYNC_STAGES-2:0], tdo_in};
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign tdo_s  = tdo_sync_q[SYNC_STAGES-1];
   assign lock_s = lock_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      tdo_d      = tdo_s;
      pend_d     = pend_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      lost_d     = lost_q;
      edge_cnt_d = edge_cnt_q;
      lock_inc   = lock_cnt_q + 16'd1;

      // A pending jitter delay always completes in the mode that started it
      if (state_q != ACTIVE || !pend_q) begin
         mode_d = mode;
      end

      unique case (state_q)
         WAIT_LOCK: begin
            lock_cnt_d = '0;
            if (lock_s) begin
               state_d = QUALIFY;
            end
         end
         QUALIFY: begin
            if (!lock_s) begin
               state_d    = WAIT_LOCK;
               lock_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_inc;
               if (lock_inc == LOCK_LAST) begin
                  state_d = ACTIVE;
               end
            end
         end
         ACTIVE: begin
            if (!lock_s) begin
               state_d    = WAIT_LOCK;
               lock_cnt_d = '0;
               lost_d     = 1'b1;
               pend_d     = 1'b0;
               cnt_d      = '0;
            end else if (mode_q[1]) begin
               tdo_d = tdo_q;
               if (!pend_q) begin
                  if (tdo_s != tdo_q) begin
                     cnt_d  = lfsr[JITTER_BITS-1:0];
                     pend_d = 1'b1;
                  end
               end else if (cnt_q == '0) begin
                  tdo_d  = tdo_s;
                  pend_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
         end
         default: begin
            state_d    = WAIT_LOCK;
            lock_cnt_d = '0;
         end
      endcase

      if (state_q == ACTIVE && tdo_d != tdo_q &&
          edge_cnt_q != 16'hFFFF) begin
         edge_cnt_d = edge_cnt_q + 16'd1;
      end

      active_d = (state_d == ACTIVE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= WAIT_LOCK;
         lock_cnt_q <= '0;
         tdo_q      <= 1'b0;
         pend_q     <= 1'b0;
         cnt_q      <= '0;
         mode_q     <= 2'b00;
         active_q   <= 1'b0;
         lost_q     <= 1'b0;
         edge_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         tdo_q      <= tdo_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         active_q   <= active_d;
         lost_q     <= lost_d;
         edge_cnt_q <= edge_cnt_d;
      end
   end

   // Bypass is combinational so reset or lock loss never holds TDO
   assign tdo_out = (state_q == ACTIVE && mode_q != MODE_BYPASS) ?
                    tdo_q : tdo_in;

   assign active     = active_q;
   assign lock_lost  = lost_q;
   assign edge_count = edge_cnt_q;

endmodule

// File: tb/tb_tdo_reclock_ctrl.sv
// Scoreboard bench for tdo_reclock_ctrl: lock qualification,
// relatch/jitter latency, pulse swallowing, lock loss, saturation.
module tb_tdo_reclock_ctrl;

   localparam int SYNC = 2;
   localparam int LOCKN = 16;
   localparam int JB = 3;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clock = 1'b0;
   logic        reset;
   logic        pll_locked;
   logic        tdo_in;
   logic [1:0]  mode;
   logic        tdo_out;
   logic        active;
   logic        lock_lost;
   logic [15:0] edge_count;

   int total = 0;
   int bad = 0;
   int exp_q[$];
   int exp_ec = 0;
   logic [15:0] m_lfsr;

   tdo_reclock_ctrl #(
      .SYNC_STAGES(SYNC),
      .LOCK_CYCLES(LOCKN),
      .JITTER_BITS(JB),
      .LFSR_SEED  (SEED)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .pll_locked(pll_locked),
      .tdo_in    (tdo_in),
      .mode      (mode),
      .tdo_out   (tdo_out),
      .active    (active),
      .lock_lost (lock_lost),
      .edge_count(edge_count)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] step(input logic [15:0] s);
      logic [15:0] n;
      n = {1'b0, s[15:1]};
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   always @(posedge clock) begin
      if (reset) m_lfsr <= SEED;
      else m_lfsr <= step(m_lfsr);
   end

   // Delay the DUT will draw if tdo_in changes right now (detect in 3 edges)
   function automatic int peek_d();
      logic [15:0] t;
      t = step(step(m_lfsr));
      return int'(t[2:0]);
   endfunction

   task automatic wait_change(input logic prev, input int limit,
                              output int lat);
      lat = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clock);
         #1;
         if (tdo_out !== prev) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic wait_peek(input int lo, input int hi, output int d);
      d = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (peek_d() >= lo && peek_d() <= hi) begin
            d = peek_d();
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pll_locked = 1'b1;
      tdo_in = 1'b0;
      mode = 2'b00;
      repeat (3) @(posedge clock);
      @(negedge clock);
      total++;
      if (active !== 1'b0) begin
         bad++; $display("FAIL reset_active got=%b want=0", active);
      end
      total++;
      if (lock_lost !== 1'b0) begin
         bad++; $display("FAIL reset_lock_lost got=%b want=0", lock_lost);
      end
      total++;
      if (edge_count !== 16'h0) begin
         bad++; $display("FAIL reset_edge_count got=%h want=0000", edge_count);
      end
      tdo_in = 1'b1;
      #1;
      total++;
      if (tdo_out !== 1'b1) begin
         bad++; $display("FAIL reset_bypass got=%b want=1", tdo_out);
      end
      tdo_in = 1'b0;
   endtask

   task automatic test_lock_qualify();
      int got;
      int follow_bad;
      got = -1;
      follow_bad = 0;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 1; i <= 60 && got < 0; i++) begin
         @(posedge clock);
         #1;
         if (active === 1'b1) begin
            got = i;
         end else begin
            @(negedge clock);
            tdo_in = (i < 6) ? i[0] : 1'b0;
            #1;
            if (tdo_out !== tdo_in) follow_bad++;
         end
      end
      total++;
      if (got != SYNC + LOCKN) begin
         bad++; $display("FAIL qualify_edges got=%0d want=%0d", got, SYNC + LOCKN);
      end
      total++;
      if (follow_bad != 0) begin
         bad++; $display("FAIL qualify_bypass mismatches=%0d want=0", follow_bad);
      end
   endtask

   task automatic test_relatch();
      int lat;
      int e;
      logic prev;
      @(negedge clock);
      mode = 2'b01;
      repeat (3) @(negedge clock);
      total++;
      if (edge_count !== 16'd0) begin
         bad++; $display("FAIL relatch_ec0 got=%0d want=0", edge_count);
      end
      prev = tdo_out;
      tdo_in = 1'b1;
      exp_q.push_back(SYNC + 1);
      exp_ec++;
      wait_change(prev, 20, lat);
      e = exp_q.pop_front();
      total++;
      if (lat != e) begin
         bad++; $display("FAIL relatch_latency got=%0d want=%0d", lat, e);
      end
      total++;
      if (tdo_out !== 1'b1 || edge_count !== 16'(exp_ec)) begin
         bad++;
         $display("FAIL relatch_out got=%b/%0d want=1/%0d", tdo_out, edge_count, exp_ec);
      end
   endtask

   task automatic test_jitter();
      int lat;
      int e;
      int d;
      logic prev;
      @(negedge clock);
      mode = 2'b10;
      repeat (3) @(negedge clock);
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clock);
         d = peek_d();
         prev = tdo_out;
         tdo_in = ~tdo_in;
         exp_q.push_back(SYNC + 2 + d);
         exp_ec++;
         wait_change(prev, 40, lat);
         e = exp_q.pop_front();
         total++;
         if (lat != e) begin
            bad++; $display("FAIL jitter_latency[%0d] got=%0d want=%0d", k, lat, e);
         end
      end
      total++;
      if (edge_count !== 16'(exp_ec)) begin
         bad++; $display("FAIL jitter_ec got=%0d want=%0d", edge_count, exp_ec);
      end
   endtask

   task automatic test_pulse();
      int lat;
      int e;
      int d;
      int glitch;
      logic prev;
      logic saw;
      @(negedge clock);
      d = peek_d();
      prev = tdo_out;
      tdo_in = 1'b0;
      exp_q.push_back(SYNC + 2 + d);
      exp_ec++;
      wait_change(prev, 40, lat);
      e = exp_q.pop_front();
      total++;
      if (lat != e) begin
         bad++; $display("FAIL pulse_setup_latency got=%0d want=%0d", lat, e);
      end
      wait_peek(5, 5, d);
      total++;
      if (d != 5) begin
         bad++; $display("FAIL pulse_find_d5 got=%0d want=5", d);
      end
      glitch = 0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clock);
         tdo_in = (i == 0);
         @(posedge clock);
         #1;
         if (tdo_out !== 1'b0) glitch++;
      end
      total++;
      if (glitch != 0) begin
         bad++; $display("FAIL short_pulse_out highs=%0d want=0", glitch);
      end
      total++;
      if (edge_count !== 16'(exp_ec)) begin
         bad++; $display("FAIL short_pulse_ec got=%0d want=%0d", edge_count, exp_ec);
      end
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         tdo_in = (i < 10);
         @(posedge clock);
         #1;
         if (tdo_out === 1'b1) saw = 1'b1;
      end
      exp_ec += 2;
      total++;
      if (saw !== 1'b1 || tdo_out !== 1'b0) begin
         bad++; $display("FAIL long_pulse_out saw=%b end=%b want=1/0", saw, tdo_out);
      end
      total++;
      if (edge_count !== 16'(exp_ec)) begin
         bad++; $display("FAIL long_pulse_ec got=%0d want=%0d", edge_count, exp_ec);
      end
   endtask

   task automatic test_mode_change();
      int lat;
      int e;
      int d;
      logic prev;
      wait_peek(4, 7, d);
      prev = tdo_out;
      tdo_in = 1'b1;
      exp_q.push_back(SYNC + 2 + d);
      exp_ec++;
      lat = -1;
      for (int i = 1; i <= 30 && lat < 0; i++) begin
         @(posedge clock);
         #1;
         if (tdo_out !== prev) lat = i;
         if (i == SYNC + 1) mode = 2'b01;
      end
      e = exp_q.pop_front();
      total++;
      if (lat != e) begin
         bad++; $display("FAIL mode_change_pending got=%0d want=%0d", lat, e);
      end
      @(negedge clock);
      prev = tdo_out;
      tdo_in = 1'b0;
      exp_q.push_back(SYNC + 1);
      exp_ec++;
      wait_change(prev, 40, lat);
      e = exp_q.pop_front();
      total++;
      if (lat != e) begin
         bad++; $display("FAIL mode_change_relatch got=%0d want=%0d", lat, e);
      end
      total++;
      if (edge_count !== 16'(exp_ec)) begin
         bad++; $display("FAIL mode_change_ec got=%0d want=%0d", edge_count, exp_ec);
      end
   endtask

   task automatic test_lock_loss();
      int n;
      @(negedge clock);
      total++;
      if (active !== 1'b1 || lock_lost !== 1'b0) begin
         bad++; $display("FAIL pre_loss got=%b/%b want=1/0", active, lock_lost);
      end
      pll_locked = 1'b0;
      @(negedge clock);
      pll_locked = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      total++;
      if (active !== 1'b0 || lock_lost !== 1'b1) begin
         bad++; $display("FAIL loss_state got=%b/%b want=0/1", active, lock_lost);
      end
      @(negedge clock);
      tdo_in = ~tdo_in;
      #1;
      total++;
      if (tdo_out !== tdo_in) begin
         bad++; $display("FAIL loss_bypass got=%b want=%b", tdo_out, tdo_in);
      end
      total++;
      if (edge_count !== 16'(exp_ec)) begin
         bad++; $display("FAIL loss_ec got=%0d want=%0d", edge_count, exp_ec);
      end
      n = 2;
      for (int i = 0; i < 60; i++) begin
         @(posedge clock);
         #1;
         n++;
         if (active === 1'b1) break;
      end
      total++;
      if (n != SYNC + LOCKN) begin
         bad++; $display("FAIL requalify_edges got=%0d want=%0d", n, SYNC + LOCKN);
      end
      total++;
      if (lock_lost !== 1'b1) begin
         bad++; $display("FAIL lock_lost_sticky got=%b want=1", lock_lost);
      end
   endtask

   task automatic test_saturation();
      int lat;
      int e;
      logic prev;
      repeat (4) @(negedge clock);
      force dut.edge_cnt_q = 16'hFFFE;
      #1;
      release dut.edge_cnt_q;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         prev = tdo_out;
         tdo_in = ~tdo_in;
         exp_q.push_back(SYNC + 1);
         wait_change(prev, 20, lat);
         e = exp_q.pop_front();
         total++;
         if (lat != e) begin
            bad++; $display("FAIL sat_latency[%0d] got=%0d want=%0d", k, lat, e);
         end
         total++;
         if (edge_count !== 16'hFFFF) begin
            bad++; $display("FAIL sat_ec[%0d] got=%h want=ffff", k, edge_count);
         end
      end
   endtask

   task automatic test_reset_mid_delay();
      int d;
      logic prev;
      @(negedge clock);
      mode = 2'b10;
      repeat (3) @(negedge clock);
      wait_peek(4, 7, d);
      prev = tdo_out;
      tdo_in = ~tdo_in;
      repeat (SYNC + 1) @(posedge clock);
      @(negedge clock);
      total++;
      if (tdo_out !== prev) begin
         bad++; $display("FAIL mid_delay_hold got=%b want=%b", tdo_out, prev);
      end
      reset = 1'b1;
      @(posedge clock);
      #1;
      total++;
      if (active !== 1'b0 || lock_lost !== 1'b0 || edge_count !== 16'h0) begin
         bad++;
         $display("FAIL mid_reset_state got=%b/%b/%h want=0/0/0000", active, lock_lost, edge_count);
      end
      total++;
      if (tdo_out !== tdo_in) begin
         bad++; $display("FAIL mid_reset_bypass got=%b want=%b", tdo_out, tdo_in);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lock_qualify();
      test_relatch();
      test_jitter();
      test_pulse();
      test_mode_change();
      test_lock_loss();
      test_saturation();
      test_reset_mid_delay();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
